uart_rx_counter_unpack: RTL and testbench
=========================================

Name: uart_rx_counter_unpack

Overview:
Host-side receiver for the cache-event counter telemetry link. It deserialises the 8N1 UART stream and frames bytes into counter packets of the form header, counter id, then value bytes MSB-first. It emits one-cycle counter records (id, value) for downstream display or logging logic. It sits at the far end of the serial line from the counter/FIFO/UART-TX top.

Parameters:
CLKS_PER_BIT, 217, clock cycles per UART bit (25 MHz / 115200); minimum 4
COUNT_BYTES, 4, value bytes per packet; COUNT_W = 8*COUNT_BYTES (localparam)
NUM_CNT, 8, number of valid counter ids (0..NUM_CNT-1)
HEADER, 8'hA5, packet start byte

Ports:
clk  in  1  system clock
rstn  in  1  reset; synchronous, active-low
rx_data  in  1  serial line, idle high, asynchronous to clk
byte_valid  out  1  one-cycle pulse, byte_data valid
byte_data  out  8  last good received byte
cnt_valid  out  1  one-cycle pulse, complete packet decoded
cnt_id  out  3  counter id of last complete packet
cnt_value  out  COUNT_W  value of last complete packet
frame_err  out  1  one-cycle pulse, stop bit sampled low
pkt_err  out  1  one-cycle pulse, packet aborted (bad id or frame error mid-packet)

Behaviour:
- Reset (rstn=0 at posedge): all outputs 0; synchroniser flops set to 1; both FSMs to idle; partial byte/packet discarded.
- rx_data passes through a 2-flop synchroniser -> rx_s (2 cycles latency).
- Bit FSM: IDLE, START, DATA, STOP, WAIT_HI.
  - IDLE: rx_s==0 -> START, tick counter cleared.
  - START: at tick CLKS_PER_BIT/2-1, rx_s==0 -> DATA; otherwise IDLE (glitch rejected).
  - DATA: sample every CLKS_PER_BIT ticks, LSB first; after 8 bits -> STOP.
  - STOP: sample after CLKS_PER_BIT ticks. If rx_s==1: byte_valid=1 for 1 cycle, byte_data updated, -> IDLE. If rx_s==0: frame_err pulse, byte dropped, -> WAIT_HI.
  - WAIT_HI: stay until rx_s==1, then -> IDLE.
- Back-to-back bytes with no idle gap are supported: a start edge is accepted the cycle after leaving STOP.
- Packet FSM (advances only on good bytes): P_HDR, P_ID, P_DATA.
  - P_HDR: byte==HEADER -> P_ID; any other byte is silently dropped.
  - P_ID: byte<NUM_CNT -> latch id, byte index=0, -> P_DATA. Otherwise pkt_err pulse, -> P_HDR.
  - P_DATA: shift register <= {shift[COUNT_W-9:0], byte}. On the COUNT_BYTES-th byte -> P_HDR, and on the following cycle cnt_valid=1, cnt_id/cnt_value updated.
  - HEADER values appearing inside P_DATA are data, not resync.
- frame_err while packet FSM is in P_ID or P_DATA: pkt_err pulses in the same cycle as frame_err, and the packet FSM -> P_HDR.
- Latency: cnt_valid occurs 1 cycle after the byte_valid of the last value byte. cnt_id/cnt_value hold until the next complete packet. A partial packet never alters them.
- cnt_valid and a new byte_valid can never coincide with a conflicting update: minimum byte period is 10*CLKS_PER_BIT.

Decomposition:
- Shared package: HEADER default, bit-FSM and packet-FSM state enums, COUNT_BYTES default (shared with the TX packer).
- Sub-module uart_rx_byte: synchroniser + bit FSM, outputs byte_valid/byte_data/frame_err.
- The top level holds the packet FSM.

Test Plan:
- CLKS_PER_BIT=4; send A5,02,00,00,01,2C -> exactly one cnt_valid, cnt_id=2, cnt_value=32'h0000012C, one cycle after 6th byte_valid.
- Send 11,5A, then A5,07,DE,AD,BE,EF with no idle gaps -> no output for the first two bytes; one cnt_valid, id=7, value=32'hDEADBEEF.
- Send A5,01,00, then a byte with stop bit held low, then line high -> frame_err and pkt_err in the same cycle, no cnt_valid. A following A5,01,00,00,00,05 -> id=1, value=5.
- Send A5,09 -> pkt_err pulse, no cnt_valid. Next valid packet A5,00,A5,A5,A5,A5 -> id=0, value=32'hA5A5A5A5.
- Low glitch of 1 cycle on rx_data -> no byte_valid, no frame_err.
- Assert rstn=0 for 2 cycles after 3 bytes of a packet, then send a full packet A5,03,00,00,00,10 -> outputs 0 during reset; single cnt_valid, id=3, value=16.

Source files
------------

// File: rtl/uart_rx_counter_unpack_pkg.sv
// Shared types and defaults for the counter telemetry link.
// The TX-side packer uses the same header and packet length.
package uart_rx_counter_unpack_pkg;

  localparam logic [7:0] HEADER_DEF      = 8'hA5;
  localparam int         COUNT_BYTES_DEF = 4;
  localparam int         ID_W            = 3;

  typedef enum logic [2:0] {
    B_IDLE,
    B_START,
    B_DATA,
    B_STOP,
    B_WAIT_HI
  } bit_state_e;

  typedef enum logic [1:0] {
    P_HDR,
    P_ID,
    P_DATA
  } pkt_state_e;

endpackage

// File: rtl/uart_rx_counter_unpack_if.sv
// Serial input and decoded byte/record outputs of the
// counter telemetry receiver.
interface uart_rx_counter_unpack_if
  import uart_rx_counter_unpack_pkg::*;
#(
  parameter int COUNT_W = 32
) ();

  logic               rx_data;
  logic               byte_valid;
  logic [7:0]         byte_data;
  logic               cnt_valid;
  logic [ID_W-1:0]    cnt_id;
  logic [COUNT_W-1:0] cnt_value;
  logic               frame_err;
  logic               pkt_err;

  modport slave (
    input  rx_data,
    output byte_valid,
    output byte_data,
    output cnt_valid,
    output cnt_id,
    output cnt_value,
    output frame_err,
    output pkt_err
  );

  modport master (
    output rx_data,
    input  byte_valid,
    input  byte_data,
    input  cnt_valid,
    input  cnt_id,
    input  cnt_value,
    input  frame_err,
    input  pkt_err
  );

endinterface

// File: rtl/uart_rx_counter_unpack_byte.sv
// 8N1 byte receiver: 2-flop synchroniser and bit FSM with
// mid-bit sampling, glitch rejection and framing check.
module uart_rx_byte
  import uart_rx_counter_unpack_pkg::*;
#(
  parameter int CLKS_PER_BIT = 217
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       rx_i,
  output logic       byte_valid_o,
  output logic [7:0] byte_data_o,
  output logic       frame_err_o
);

  localparam int            CW   = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] FULL = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] ONE  = CW'(1);

  bit_state_e    state_q;
  logic [1:0]    sync_q;
  logic [CW-1:0] tick_q;
  logic [2:0]    bit_q;
  logic [7:0]    shift_q;
  logic          byte_valid_q;
  logic [7:0]    byte_data_q;
  logic          frame_err_q;
  logic          rx_s;

  assign rx_s = sync_q[1];

  always_ff @(posedge clk) begin
    if (!rstn) begin
      sync_q       <= 2'b11;
      state_q      <= B_IDLE;
      tick_q       <= '0;
      bit_q        <= '0;
      shift_q      <= '0;
      byte_valid_q <= 1'b0;
      byte_data_q  <= '0;
      frame_err_q  <= 1'b0;
    end else begin
      sync_q       <= {sync_q[0], rx_i};
      byte_valid_q <= 1'b0;
      frame_err_q  <= 1'b0;
      unique case (state_q)
        B_IDLE: begin
          if (!rx_s) begin
            state_q <= B_START;
            tick_q  <= '0;
          end
        end
        B_START: begin
          if (tick_q == HALF) begin
            tick_q  <= '0;
            bit_q   <= '0;
            state_q <= rx_s ? B_IDLE : B_DATA;
          end else begin
            tick_q <= tick_q + ONE;
          end
        end
        B_DATA: begin
          if (tick_q == FULL) begin
            tick_q  <= '0;
            shift_q <= {rx_s, shift_q[7:1]};
            bit_q   <= bit_q + 3'd1;
            if (bit_q == 3'd7) state_q <= B_STOP;
          end else begin
            tick_q <= tick_q + ONE;
          end
        end
        B_STOP: begin
          if (tick_q == FULL) begin
            tick_q <= '0;
            if (rx_s) begin
              byte_valid_q <= 1'b1;
              byte_data_q  <= shift_q;
              state_q      <= B_IDLE;
            end else begin
              frame_err_q <= 1'b1;
              state_q     <= B_WAIT_HI;
            end
          end else begin
            tick_q <= tick_q + ONE;
          end
        end
        B_WAIT_HI: begin
          if (rx_s) state_q <= B_IDLE;
        end
        default: state_q <= B_IDLE;
      endcase
    end
  end

  assign byte_valid_o = byte_valid_q;
  assign byte_data_o  = byte_data_q;
  assign frame_err_o  = frame_err_q;

endmodule

// File: rtl/uart_rx_counter_unpack.sv
// Counter telemetry receiver: frames UART bytes into
// header/id/value packets and emits one-cycle records.
module uart_rx_counter_unpack
  import uart_rx_counter_unpack_pkg::*;
#(
  parameter int         CLKS_PER_BIT = 217,
  parameter int         COUNT_BYTES  = COUNT_BYTES_DEF,
  parameter int         NUM_CNT      = 8,
  parameter logic [7:0] HEADER       = HEADER_DEF
) (
  input logic                     clk,
  input logic                     rstn,
  uart_rx_counter_unpack_if.slave bus
);

  localparam int         COUNT_W  = 8 * COUNT_BYTES;
  localparam logic [8:0] NUM_L    = 9'(NUM_CNT);
  localparam logic [7:0] LAST_IDX = 8'(COUNT_BYTES - 1);

  logic       byte_valid;
  logic [7:0] byte_data;
  logic       frame_err;

  uart_rx_byte #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_byte (
    .clk         (clk),
    .rstn        (rstn),
    .rx_i        (bus.rx_data),
    .byte_valid_o(byte_valid),
    .byte_data_o (byte_data),
    .frame_err_o (frame_err)
  );

  pkt_state_e         pst_q;
  logic [ID_W-1:0]    id_q;
  logic [7:0]         idx_q;
  logic [COUNT_W-1:0] shift_q;
  logic [COUNT_W-1:0] shift_d;
  logic               cnt_valid_q;
  logic [ID_W-1:0]    cnt_id_q;
  logic [COUNT_W-1:0] cnt_value_q;
  logic               id_ok;
  logic               pkt_err_d;

  assign shift_d = (shift_q << 8) | COUNT_W'(byte_data);
  assign id_ok   = {1'b0, byte_data} < NUM_L;

  // Combinational so the abort lines up with frame_err.
  always_comb begin
    pkt_err_d = 1'b0;
    if (byte_valid && pst_q == P_ID && !id_ok) pkt_err_d = 1'b1;
    if (frame_err && pst_q != P_HDR) pkt_err_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      pst_q       <= P_HDR;
      id_q        <= '0;
      idx_q       <= '0;
      shift_q     <= '0;
      cnt_valid_q <= 1'b0;
      cnt_id_q    <= '0;
      cnt_value_q <= '0;
    end else begin
      cnt_valid_q <= 1'b0;
      if (frame_err) begin
        pst_q <= P_HDR;
      end else if (byte_valid) begin
        unique case (pst_q)
          P_HDR: begin
            if (byte_data == HEADER) pst_q <= P_ID;
          end
          P_ID: begin
            if (id_ok) begin
              id_q  <= byte_data[ID_W-1:0];
              idx_q <= '0;
              pst_q <= P_DATA;
            end else begin
              pst_q <= P_HDR;
            end
          end
          P_DATA: begin
            shift_q <= shift_d;
            idx_q   <= idx_q + 8'd1;
            if (idx_q == LAST_IDX) begin
              pst_q       <= P_HDR;
              cnt_valid_q <= 1'b1;
              cnt_id_q    <= id_q;
              cnt_value_q <= shift_d;
            end
          end
          default: pst_q <= P_HDR;
        endcase
      end
    end
  end

  assign bus.byte_valid = byte_valid;
  assign bus.byte_data  = byte_data;
  assign bus.frame_err  = frame_err;
  assign bus.pkt_err    = pkt_err_d;
  assign bus.cnt_valid  = cnt_valid_q;
  assign bus.cnt_id     = cnt_id_q;
  assign bus.cnt_value  = cnt_value_q;

endmodule

// File: tb/tb_uart_rx_counter_unpack.sv
// Bench for the counter telemetry receiver: directed packets
// plus random streams against a byte-level packet model.
module tb_uart_rx_counter_unpack;

  localparam int CPB = 4;
  localparam int NB  = 4;
  localparam int CW  = 8 * NB;
  localparam int NUM = 8;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  uart_rx_counter_unpack_if #(.COUNT_W(CW)) bus ();

  uart_rx_counter_unpack #(
    .CLKS_PER_BIT(CPB),
    .COUNT_BYTES (NB),
    .NUM_CNT     (NUM),
    .HEADER      (8'hA5)
  ) dut (
    .clk (clk),
    .rstn(rstn),
    .bus (bus.slave)
  );

  int total = 0;
  int bad   = 0;

  logic [7:0]    got_bytes[$];
  int            got_id[$];
  logic [CW-1:0] got_val[$];
  logic          got_prev[$];
  int            n_fe, n_pe, n_both;
  logic          prev_bv = 1'b0;

  always @(negedge clk) begin
    if (rstn) begin
      if (bus.byte_valid) got_bytes.push_back(bus.byte_data);
      if (bus.cnt_valid) begin
        got_id.push_back(int'(bus.cnt_id));
        got_val.push_back(bus.cnt_value);
        got_prev.push_back(prev_bv);
      end
      if (bus.frame_err) n_fe++;
      if (bus.pkt_err) n_pe++;
      if (bus.frame_err && bus.pkt_err) n_both++;
    end
    prev_bv <= bus.byte_valid;
  end

  // Packet model: header, id below NUM, then NB bytes MSB-first.
  int            m_st, m_n, m_id;
  logic [CW-1:0] m_val;
  logic [7:0]    exp_bytes[$];
  int            exp_id[$];
  logic [CW-1:0] exp_val[$];
  int            exp_pe, exp_fe;

  task automatic model_reset();
    m_st = 0;
    m_n  = 0;
  endtask

  task automatic model_byte(input logic [7:0] b, input logic good);
    if (!good) begin
      exp_fe++;
      if (m_st != 0) exp_pe++;
      m_st = 0;
    end else begin
      exp_bytes.push_back(b);
      if (m_st == 0) begin
        if (b == 8'hA5) m_st = 1;
      end else if (m_st == 1) begin
        if (int'(b) < NUM) begin
          m_id = int'(b);
          m_val = '0;
          m_n = 0;
          m_st = 2;
        end else begin
          exp_pe++;
          m_st = 0;
        end
      end else begin
        m_val = m_val * 256 + CW'(b);
        m_n++;
        if (m_n == NB) begin
          exp_id.push_back(m_id);
          exp_val.push_back(m_val);
          m_st = 0;
        end
      end
    end
  endtask

  task automatic clear_logs();
    got_bytes.delete();
    got_id.delete();
    got_val.delete();
    got_prev.delete();
    exp_bytes.delete();
    exp_id.delete();
    exp_val.delete();
    n_fe = 0;
    n_pe = 0;
    n_both = 0;
    exp_pe = 0;
    exp_fe = 0;
  endtask

  task automatic hold(input logic v, input int n);
    bus.rx_data = v;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop);
    model_byte(b, stop);
    hold(1'b0, CPB);
    for (int i = 0; i < 8; i++) hold(b[i], CPB);
    hold(stop, CPB);
    if (!stop) hold(1'b1, 2 * CPB);
  endtask

  task automatic send_bytes(input logic [63:0] v, input int n,
                            input int gap);
    for (int i = 0; i < n; i++) begin
      send_byte(v[8*(n-1-i) +: 8], 1'b1);
      hold(1'b1, gap);
    end
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    bus.rx_data = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    total++;
    if ({bus.byte_valid, bus.byte_data, bus.cnt_valid, bus.cnt_id,
         bus.cnt_value, bus.frame_err, bus.pkt_err} !== 47'd0) begin
      bad++;
      $display("FAIL reset_outputs got=%h want=0",
               {bus.cnt_valid, bus.cnt_id, bus.cnt_value});
    end
    @(posedge clk);
    #1;
    rstn = 1'b1;
    model_reset();
    hold(1'b1, 6);
  endtask

  task automatic test_basic();
    clear_logs();
    send_bytes(64'hA5_02_00_00_01_2C, 6, 2);
    hold(1'b1, 12);
    total++;
    if (got_bytes.size() != 6) begin
      bad++;
      $display("FAIL basic_bytes got=%0d want=6", got_bytes.size());
    end
    total++;
    if (got_id.size() != 1) begin
      bad++;
      $display("FAIL basic_count got=%0d want=1", got_id.size());
    end else begin
      total++;
      if (got_id[0] !== 2 || got_val[0] !== 32'h0000012C) begin
        bad++;
        $display("FAIL basic_rec got=%0d/%h want=2/0000012c",
                 got_id[0], got_val[0]);
      end
      total++;
      if (got_prev[0] !== 1'b1) begin
        bad++;
        $display("FAIL basic_latency got=%b want=1", got_prev[0]);
      end
    end
  endtask

  task automatic test_back_to_back();
    clear_logs();
    send_bytes(64'h11_5A_A5_07_DE_AD_BE_EF, 8, 0);
    hold(1'b1, 12);
    total++;
    if (got_bytes.size() != 8 || n_pe != 0) begin
      bad++;
      $display("FAIL b2b_bytes got=%0d pe=%0d want=8 pe=0",
               got_bytes.size(), n_pe);
    end
    total++;
    if (got_id.size() != 1) begin
      bad++;
      $display("FAIL b2b_count got=%0d want=1", got_id.size());
    end else begin
      total++;
      if (got_id[0] !== 7 || got_val[0] !== 32'hDEADBEEF
          || got_prev[0] !== 1'b1) begin
        bad++;
        $display("FAIL b2b_rec got=%0d/%h want=7/deadbeef",
                 got_id[0], got_val[0]);
      end
    end
  endtask

  task automatic test_frame_err();
    clear_logs();
    send_bytes(64'hA5_01_00, 3, 1);
    send_byte(8'h33, 1'b0);
    hold(1'b1, 6);
    total++;
    if (n_fe != 1 || n_pe != 1 || n_both != 1 || got_id.size() != 0)
    begin
      bad++;
      $display("FAIL frame_abort got fe=%0d pe=%0d both=%0d cv=%0d want 1/1/1/0",
               n_fe, n_pe, n_both, got_id.size());
    end
    send_bytes(64'hA5_01_00_00_00_05, 6, 1);
    hold(1'b1, 12);
    total++;
    if (got_id.size() != 1) begin
      bad++;
      $display("FAIL frame_count got=%0d want=1", got_id.size());
    end else begin
      total++;
      if (got_id[0] !== 1 || got_val[0] !== 32'd5) begin
        bad++;
        $display("FAIL frame_rec got=%0d/%h want=1/00000005",
                 got_id[0], got_val[0]);
      end
    end
  endtask

  task automatic test_bad_id();
    clear_logs();
    send_bytes(64'hA5_09, 2, 1);
    hold(1'b1, 12);
    total++;
    if (n_pe != 1 || n_fe != 0 || got_id.size() != 0) begin
      bad++;
      $display("FAIL badid got pe=%0d fe=%0d cv=%0d want 1/0/0",
               n_pe, n_fe, got_id.size());
    end
    send_bytes(64'hA5_00_A5_A5_A5_A5, 6, 0);
    hold(1'b1, 12);
    total++;
    if (got_id.size() != 1) begin
      bad++;
      $display("FAIL badid_count got=%0d want=1", got_id.size());
    end else begin
      total++;
      if (got_id[0] !== 0 || got_val[0] !== 32'hA5A5A5A5) begin
        bad++;
        $display("FAIL badid_rec got=%0d/%h want=0/a5a5a5a5",
                 got_id[0], got_val[0]);
      end
    end
  endtask

  task automatic test_glitch();
    clear_logs();
    hold(1'b0, 1);
    hold(1'b1, 20);
    total++;
    if (got_bytes.size() != 0 || n_fe != 0) begin
      bad++;
      $display("FAIL glitch got bytes=%0d fe=%0d want 0/0",
               got_bytes.size(), n_fe);
    end
  endtask

  task automatic test_reset_mid();
    clear_logs();
    send_bytes(64'hA5_03_00, 3, 1);
    rstn = 1'b0;
    @(posedge clk);
    @(negedge clk);
    total++;
    if ({bus.byte_valid, bus.cnt_valid, bus.cnt_id, bus.cnt_value,
         bus.frame_err, bus.pkt_err} !== 39'd0) begin
      bad++;
      $display("FAIL rstmid_outputs got id=%0d val=%h want 0",
               bus.cnt_id, bus.cnt_value);
    end
    @(posedge clk);
    #1;
    rstn = 1'b1;
    model_reset();
    clear_logs();
    hold(1'b1, 4);
    send_bytes(64'hA5_03_00_00_00_10, 6, 1);
    hold(1'b1, 12);
    total++;
    if (got_id.size() != 1) begin
      bad++;
      $display("FAIL rstmid_count got=%0d want=1", got_id.size());
    end else begin
      total++;
      if (got_id[0] !== 3 || got_val[0] !== 32'd16) begin
        bad++;
        $display("FAIL rstmid_rec got=%0d/%h want=3/00000010",
                 got_id[0], got_val[0]);
      end
    end
  endtask

  task automatic test_random();
    logic [7:0] b;
    clear_logs();
    for (int p = 0; p < 24; p++) begin
      if ($urandom_range(0, 3) == 0) begin
        send_byte(8'($urandom), 1'b1);
        hold(1'b1, $urandom_range(0, 2));
      end
      send_byte(8'hA5, 1'b1);
      send_byte(8'($urandom_range(0, 9)), 1'b1);
      hold(1'b1, $urandom_range(0, 2));
      for (int k = 0; k < NB; k++) begin
        b = 8'($urandom);
        if ($urandom_range(0, 19) == 0) send_byte(b, 1'b0);
        else send_byte(b, 1'b1);
        hold(1'b1, $urandom_range(0, 2));
      end
    end
    hold(1'b1, 12);
    total++;
    if (got_id.size() != exp_id.size()) begin
      bad++;
      $display("FAIL rand_count got=%0d want=%0d",
               got_id.size(), exp_id.size());
    end
    for (int i = 0; i < got_id.size() && i < exp_id.size(); i++) begin
      total++;
      if (got_id[i] !== exp_id[i] || got_val[i] !== exp_val[i]
          || got_prev[i] !== 1'b1) begin
        bad++;
        $display("FAIL rand_rec[%0d] got=%0d/%h want=%0d/%h",
                 i, got_id[i], got_val[i], exp_id[i], exp_val[i]);
      end
    end
    total++;
    if (got_bytes.size() != exp_bytes.size()) begin
      bad++;
      $display("FAIL rand_bytes got=%0d want=%0d",
               got_bytes.size(), exp_bytes.size());
    end
    for (int i = 0; i < got_bytes.size() && i < exp_bytes.size(); i++)
    begin
      total++;
      if (got_bytes[i] !== exp_bytes[i]) begin
        bad++;
        $display("FAIL rand_byte[%0d] got=%h want=%h",
                 i, got_bytes[i], exp_bytes[i]);
      end
    end
    total++;
    if (n_pe != exp_pe || n_fe != exp_fe) begin
      bad++;
      $display("FAIL rand_errs got pe=%0d fe=%0d want pe=%0d fe=%0d",
               n_pe, n_fe, exp_pe, exp_fe);
    end
  endtask

  initial begin
    bus.rx_data = 1'b1;
    model_reset();
    clear_logs();
    test_reset();
    test_basic();
    test_back_to_back();
    test_frame_err();
    test_bad_id();
    test_glitch();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
